// File: rtl/clken_gen_pkg.sv
// clken_gen_pkg: shared types and helpers for the clock-enable generator.
// Holds the sequencer state enum, default sizes and the NCO increment helper.
package clken_gen_pkg;

  localparam int NUM_CH_MAX = 8;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_e;

  // round(f_out * 2^acc_w / f_clk); elaboration-time use only.
  function automatic longint calc_incr(
    input real f_out,
    input real f_clk,
    input int  acc_w
  );
    real x;
    x = f_out * (2.0 ** acc_w) / f_clk;
    return longint'(x);
  endfunction

endpackage

// File: rtl/clken_nco.sv
// clken_nco: one phase-accumulator clock-enable channel.
// Ports: clk, reset (async high), clr (sync zero), en, incr -> clken pulse.
module clken_nco
  import clken_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] incr,
  output logic             clken
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             clken_q, clken_d;
  logic [ACC_W:0]   sum;

  // Carry out of the add is the pulse; residue stays in acc.
  assign sum = {1'b0, acc_q} + {1'b0, incr};

  always_comb begin
    acc_d   = acc_q;
    clken_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      {clken_d, acc_d} = sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      clken_q <= clken_d;
    end
  end

  assign clken = clken_q;

endmodule

// File: rtl/clken_gen.sv
// clken_gen: PLL lock filter, staged channel reset release, NCO clock enables.
// Ports: clk, reset, pll_locked, ch_incr, ch_en -> locked, ch_rst, ch_clken.
// Option CLKEN_GEN_PHASE_SYNC_EN adds phase_sync (zero all accumulators).
module clken_gen
  import clken_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int LOCK_FILT = 1024,
  parameter int RST_GAP   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] ch_incr,
  input  logic [NUM_CH-1:0]       ch_en,
`ifdef CLKEN_GEN_PHASE_SYNC_EN
  input  logic                    phase_sync,
`endif
  output logic                    locked,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic [NUM_CH-1:0]       ch_clken
);

  localparam int CNT_W = $clog2(LOCK_FILT);
  localparam int GAP_W = (RST_GAP > 1) ? $clog2(RST_GAP) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RST_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_CH - 1);

  logic lk_m_q, lk_s_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e            state_q, state_d;
  logic              locked_q, locked_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_m_q <= 1'b0;
      lk_s_q <= 1'b0;
    end else begin
      lk_m_q <= pll_locked;
      lk_s_q <= lk_m_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!lk_s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    rst_d    = rst_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    unique case (state_q)
      S_WAIT_LOCK: begin
        locked_d = 1'b0;
        rst_d    = '1;
        gap_d    = '0;
        idx_d    = '0;
        if (lk_s_q && cnt_q == CNT_MAX) begin
          state_d  = S_RELEASE;
          locked_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!lk_s_q) begin
          state_d  = S_WAIT_LOCK;
          locked_d = 1'b0;
          rst_d    = '1;
          gap_d    = '0;
          idx_d    = '0;
        end else if (gap_q == GAP_MAX) begin
          gap_d        = '0;
          rst_d[idx_q] = 1'b0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IDX_MAX) begin
            state_d = S_RUN;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk_s_q) begin
          state_d  = S_WAIT_LOCK;
          locked_d = 1'b0;
          rst_d    = '1;
          gap_d    = '0;
          idx_d    = '0;
        end
      end
      default: begin
        state_d  = S_WAIT_LOCK;
        locked_d = 1'b0;
        rst_d    = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      state_q  <= S_WAIT_LOCK;
      locked_q <= 1'b0;
      rst_q    <= '1;
      gap_q    <= '0;
      idx_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      locked_q <= locked_d;
      rst_q    <= rst_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
    end
  end

  assign locked = locked_q;
  assign ch_rst = rst_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic clr;
`ifdef CLKEN_GEN_PHASE_SYNC_EN
    assign clr = rst_q[i] | phase_sync;
`else
    assign clr = rst_q[i];
`endif
    clken_nco #(
      .ACC_W(ACC_W)
    ) u_nco (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .en   (ch_en[i]),
      .incr (ch_incr[i*ACC_W +: ACC_W]),
      .clken(ch_clken[i])
    );
  end

endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: self-checking bench for clken_gen.
// Lock/release table, NCO pulse scoreboard, glitch and lock-loss sequences.
module tb_clken_gen;
  import clken_gen_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int LF  = 8;
  localparam int RG  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              pll_locked;
  logic [NCH*AW-1:0] ch_incr;
  logic [NCH-1:0]    ch_en;
`ifdef CLKEN_GEN_PHASE_SYNC_EN
  logic              phase_sync;
`endif
  logic              locked;
  logic [NCH-1:0]    ch_rst;
  logic [NCH-1:0]    ch_clken;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit      sb_on = 1'b0;
  longint  nadd[NCH];
  int      npulse[NCH];
  int      expq[NCH][$];

  typedef struct {
    int         cyc;
    logic       lk;
    logic [3:0] rst;
  } lkvec_t;

  always #5 clk = ~clk;

  clken_gen #(
    .NUM_CH   (NCH),
    .ACC_W    (AW),
    .LOCK_FILT(LF),
    .RST_GAP  (RG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .ch_incr   (ch_incr),
    .ch_en     (ch_en),
`ifdef CLKEN_GEN_PHASE_SYNC_EN
    .phase_sync(phase_sync),
`endif
    .locked    (locked),
    .ch_rst    (ch_rst),
    .ch_clken  (ch_clken)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Scoreboard push on drive, pop/compare on output.
  task automatic tick();
    longint unsigned inc, a, b;
    bit exp_now;
    if (sb_on) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_en[c]) begin
          inc = longint'(ch_incr[c*AW +: AW]);
          nadd[c]++;
          a = (longint'(nadd[c]) * inc) >> AW;
          b = (longint'(nadd[c] - 1) * inc) >> AW;
          if (a != b) expq[c].push_back(cyc + 1);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on) begin
      for (int c = 0; c < NCH; c++) begin
        exp_now = (expq[c].size() > 0) && (expq[c][0] == cyc);
        if (exp_now) void'(expq[c].pop_front());
        if (ch_clken[c] || exp_now)
          check($sformatf("clken%0d", c), 64'(ch_clken[c]), 64'(exp_now));
        if (ch_clken[c]) npulse[c]++;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lkvec_t tv[12];
    int t0, p1, lsta, r, g;
`ifdef CLKEN_GEN_PHASE_SYNC_EN
    int s;
`endif
    tv = '{'{11, 1'b0, 4'hF}, '{19, 1'b0, 4'hF}, '{20, 1'b1, 4'hF},
           '{23, 1'b1, 4'hF}, '{24, 1'b1, 4'hE}, '{27, 1'b1, 4'hE},
           '{28, 1'b1, 4'hC}, '{31, 1'b1, 4'hC}, '{32, 1'b1, 4'h8},
           '{35, 1'b1, 4'h8}, '{36, 1'b1, 4'h0}, '{40, 1'b1, 4'h0}};

    reset      = 1'b1;
    pll_locked = 1'b0;
    ch_en      = '0;
    ch_incr    = {24'h000000, 24'h555555, 24'h400000, 24'h400000};
`ifdef CLKEN_GEN_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
      nadd[c]   = 0;
      npulse[c] = 0;
    end

    check("calc_incr", 64'(calc_incr(1.0e6, 4.0e6, AW)), 64'h400000);

    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_ch_rst", 64'(ch_rst), 64'hF);
    check("rst_clken", 64'(ch_clken), 64'd0);
    reset = 1'b0;
    cyc   = 0;

    run_to(10);
    check("pre_lock", 64'(locked), 64'd0);
    pll_locked = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_to(tv[i].cyc);
      check($sformatf("seq_locked@%0d", tv[i].cyc),
            64'(locked), 64'(tv[i].lk));
      check($sformatf("seq_rst@%0d", tv[i].cyc),
            64'(ch_rst), 64'(tv[i].rst));
    end

    t0    = cyc;
    sb_on = 1'b1;
    ch_en = 4'hF;
    p1    = 0;
    for (int k = 0; k < 10000; k++) begin
      if (cyc == t0 + 3000) begin
        p1       = npulse[1];
        ch_en[1] = 1'b0;
      end
      if (cyc == t0 + 3100) begin
        check("freeze_pulses", 64'(npulse[1] - p1), 64'd0);
        ch_en[1] = 1'b1;
      end
      tick();
    end
    check("rate_ch0", 64'(npulse[0]), 64'd2500);
    check("rate_ch1", 64'(npulse[1]), 64'd2475);
    check("rate_ch2_3333pm1",
          64'((npulse[2] >= 3332) && (npulse[2] <= 3334)), 64'd1);
    check("rate_ch3_zero", 64'(npulse[3]), 64'd0);
    ch_en = '0;
    tick();
    for (int c = 0; c < NCH; c++)
      check($sformatf("sb_empty%0d", c), 64'(expq[c].size()), 64'd0);
    sb_on = 1'b0;

`ifdef CLKEN_GEN_PHASE_SYNC_EN
    ch_incr[0*AW +: AW] = 24'h400000;
    ch_incr[1*AW +: AW] = 24'h200000;
    ch_en = 4'b0011;
    repeat (7) tick();
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    s = cyc;
    check("sync_suppress", 64'(ch_clken[1:0]), 64'd0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      check($sformatf("sync_ch0_+%0d", j), 64'(ch_clken[0]),
            64'((j % 4) == 0));
      check($sformatf("sync_ch1_+%0d", j), 64'(ch_clken[1]),
            64'((j % 8) == 0));
    end
    check("sync_span", 64'(cyc - s), 64'd16);
    ch_en = '0;
    tick();
`endif

    lsta       = cyc;
    pll_locked = 1'b0;
    run_to(lsta + 2);
    check("loss_hold", 64'(locked), 64'd1);
    run_to(lsta + 3);
    check("loss_locked", 64'(locked), 64'd0);
    check("loss_rst", 64'(ch_rst), 64'hF);
    repeat (3) tick();

    r          = cyc;
    pll_locked = 1'b1;
    run_to(r + 5);
    g          = cyc;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    run_to(g + 10);
    check("glitch_wait", 64'(locked), 64'd0);
    run_to(g + 11);
    check("glitch_lock", 64'(locked), 64'd1);
    check("glitch_rst", 64'(ch_rst), 64'hF);
    run_to(g + 14);
    check("relock_rst0_hold", 64'(ch_rst), 64'hF);
    run_to(g + 15);
    check("relock_rst0", 64'(ch_rst), 64'hE);
    run_to(g + 26);
    check("relock_rst2", 64'(ch_rst), 64'h8);
    run_to(g + 27);
    check("relock_rst3", 64'(ch_rst), 64'h0);
    check("relock_locked", 64'(locked), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
